// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display frame sequencer.
//   state_t      - sequencer FSM states
//   GS_*         - game_status encodings from the game-logic block
//   FRAME_CNT_W  - width of the completed-frame counter
//   layer_w()    - layer index width for a given layer count (minimum 1)
package disp_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_HOLD   = 3'd1,
    S_ERASE  = 3'd2,
    S_UPDATE = 3'd3,
    S_DRAW   = 3'd4,
    S_END    = 3'd5
  } state_t;

  localparam logic [1:0] GS_START = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_OVER  = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b11;

  localparam int FRAME_CNT_W = 16;

  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// display_sequencer_if: sync/status/done inputs and engine-control outputs
// of the display sequencer.
//   master - game logic / engines / testbench side (drives sync, status, dones)
//   slave  - sequencer side (drives engine enables, layer index, counters)
interface display_sequencer_if
  import disp_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LW         = disp_pkg::layer_w(NUM_LAYERS)
);
  logic                   sync;
  logic [1:0]             game_status;
  logic [NUM_LAYERS-1:0]  bypass_erase;
  logic                   done_erase;
  logic                   done_draw;
  logic                   vga_en;
  logic                   draw_start;
  logic                   erase;
  logic                   update;
  logic                   draw;
  logic                   draw_end;
  logic [LW-1:0]          layer_idx;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   overrun;
  logic                   wdog_timeout;

  modport master (
    output sync, game_status, bypass_erase, done_erase, done_draw,
    input  vga_en, draw_start, erase, update, draw, draw_end,
           layer_idx, frame_cnt, overrun, wdog_timeout
  );

  modport slave (
    input  sync, game_status, bypass_erase, done_erase, done_draw,
    output vga_en, draw_start, erase, update, draw, draw_end,
           layer_idx, frame_cnt, overrun, wdog_timeout
  );
endinterface

// File: rtl/disp_layer_sel.sv
// disp_layer_sel: combinational search for the lowest non-bypassed layer
// strictly above i_idx.
//   i_bypass - per-layer erase bypass mask
//   i_idx    - current layer index
//   o_next   - next layer to erase (valid when o_found)
//   o_found  - a non-bypassed layer exists above i_idx
module disp_layer_sel #(
  parameter int NUM_LAYERS = 4,
  parameter int LW         = 2
) (
  input  logic [NUM_LAYERS-1:0] i_bypass,
  input  logic [LW-1:0]         i_idx,
  output logic [LW-1:0]         o_next,
  output logic                  o_found
);

  // Walk downward so the lowest qualifying layer is the last one written.
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if ((i > int'(i_idx)) && !i_bypass[i]) begin
        o_next  = i[LW-1:0];
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: per-frame erase/update/draw sequencer for the VGA game
// display, with start/game-over screens, pause, frame decimation, a frame
// counter and overrun detection.
//   clk   - system clock
//   reset - asynchronous, active-high
//   bus   - display_sequencer_if.slave (sync, game_status, bypass_erase,
//           done_erase/done_draw in; engine enables, layer_idx, frame_cnt,
//           overrun, wdog_timeout out)
// Optional: define DISP_SEQ_WATCHDOG_EN to add a done-pulse watchdog that
// forces an advance after WDOG_CYCLES cycles in S_ERASE/S_DRAW.
//
// state    | meaning
// S_START  | start screen engine active
// S_HOLD   | idle between frames, waiting for (decimated) sync
// S_ERASE  | erasing layer layer_idx
// S_UPDATE | one-cycle game-state update, VGA write port released
// S_DRAW   | drawing layer layer_idx
// S_END    | game-over screen, waiting for restart
module display_sequencer
  import disp_pkg::*;
#(
  parameter int NUM_LAYERS  = 4,
  parameter int FRAME_DIV   = 1,
  parameter int WDOG_CYCLES = 65535
) (
  input logic                 clk,
  input logic                 reset,
  display_sequencer_if.slave  bus
);

  localparam int            LW         = layer_w(NUM_LAYERS);
  localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);
  localparam logic [7:0]    DIV_LAST   = 8'(FRAME_DIV - 1);

  state_t                 r_state;
  logic [LW-1:0]          r_layer_idx;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [7:0]             r_div;

  logic [LW-1:0] w_next_idx;
  logic          w_next_found;
  logic          w_waiting;
  logic          w_wdog_hit;
  logic          w_adv_erase;
  logic          w_adv_draw;

  disp_layer_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .LW         (LW)
  ) u_layer_sel (
    .i_bypass (bus.bypass_erase),
    .i_idx    (r_layer_idx),
    .o_next   (w_next_idx),
    .o_found  (w_next_found)
  );

  assign w_waiting   = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_adv_erase = (r_state == S_ERASE) && (bus.done_erase || w_wdog_hit);
  assign w_adv_draw  = (r_state == S_DRAW)  && (bus.done_draw  || w_wdog_hit);

`ifdef DISP_SEQ_WATCHDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog;

  assign w_wdog_hit = w_waiting && (r_wdog == WDOG_LAST);

  // Any advance (real done or forced) restarts the count for the next layer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (!w_waiting || w_adv_erase || w_adv_draw) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_START;
      r_layer_idx <= '0;
      r_frame_cnt <= '0;
      r_div       <= '0;
    end else begin
      unique case (r_state)
        S_START: begin
          r_layer_idx <= '0;
          if (bus.game_status == GS_PLAY) r_state <= S_HOLD;
          else if (bus.game_status == GS_OVER) r_state <= S_END;
        end

        // layer_idx is 0 here, so the selector yields the lowest
        // non-bypassed layer above 0; layer 0 itself is tested directly.
        S_HOLD: begin
          if (bus.game_status == GS_START) begin
            r_state <= S_START;
          end else if (bus.game_status == GS_OVER) begin
            r_state <= S_END;
          end else if ((bus.game_status == GS_PLAY) && bus.sync) begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (!bus.bypass_erase[0]) begin
                r_state     <= S_ERASE;
                r_layer_idx <= '0;
              end else if (w_next_found) begin
                r_state     <= S_ERASE;
                r_layer_idx <= w_next_idx;
              end else begin
                r_state     <= S_UPDATE;
                r_layer_idx <= '0;
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
        end

        S_ERASE: begin
          if (w_adv_erase) begin
            if (w_next_found) begin
              r_layer_idx <= w_next_idx;
            end else begin
              r_state     <= S_UPDATE;
              r_layer_idx <= '0;
            end
          end
        end

        // Pause still finishes the frame that is already under way.
        S_UPDATE: begin
          r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
          r_layer_idx <= '0;
          if (bus.game_status == GS_START) r_state <= S_START;
          else if (bus.game_status == GS_OVER) r_state <= S_END;
          else r_state <= S_DRAW;
        end

        S_DRAW: begin
          if (w_adv_draw) begin
            if (r_layer_idx == LAYER_LAST) begin
              r_state     <= S_HOLD;
              r_layer_idx <= '0;
            end else begin
              r_layer_idx <= r_layer_idx + LW'(1);
            end
          end
        end

        S_END: begin
          if (bus.game_status == GS_START) r_state <= S_START;
        end

        default: begin
          r_state     <= S_START;
          r_layer_idx <= '0;
        end
      endcase
    end
  end

  assign bus.vga_en       = (r_state != S_UPDATE);
  assign bus.draw_start   = (r_state == S_START);
  assign bus.erase        = (r_state == S_ERASE);
  assign bus.update       = (r_state == S_UPDATE);
  assign bus.draw         = (r_state == S_DRAW);
  assign bus.draw_end     = (r_state == S_END);
  assign bus.layer_idx    = r_layer_idx;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.overrun      = bus.sync &&
                            ((r_state == S_ERASE) || (r_state == S_UPDATE) ||
                             (r_state == S_DRAW));
  assign bus.wdog_timeout = w_wdog_hit;

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: table-driven check of display_sequencer with
// NUM_LAYERS=4, FRAME_DIV=3, WDOG_CYCLES=16. Each table row holds the inputs
// for one cycle and the outputs expected during that cycle; expectations are
// queued when a row is driven and compared on the following falling edge.
// Honours DISP_SEQ_WATCHDOG_EN for the watchdog section.
module tb_display_sequencer;
  import disp_pkg::*;

  typedef struct packed {
    logic        vga_en;
    logic        draw_start;
    logic        erase;
    logic        update;
    logic        draw;
    logic        draw_end;
    logic [1:0]  idx;
    logic [15:0] fc;
    logic        ovr;
    logic        wd;
  } out_t;

  typedef struct {
    string      tag;
    logic       sync;
    logic [1:0] gs;
    logic [3:0] byp;
    logic       de;
    logic       dd;
    state_t     st;
    logic [1:0] idx;
    logic [15:0] fc;
    logic       ovr;
    logic       wd;
  } vec_t;

  typedef struct {
    string name;
    out_t  e;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_pass = 0;

  vec_t tbl[$];
  sb_t  sb[$];

  display_sequencer_if #(.NUM_LAYERS(4)) bus ();

  display_sequencer #(
    .NUM_LAYERS  (4),
    .FRAME_DIV   (3),
    .WDOG_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t dec(state_t st, logic [1:0] idx, logic [15:0] fc,
                               logic ovr, logic wd);
    out_t d;
    d.vga_en     = (st != S_UPDATE);
    d.draw_start = (st == S_START);
    d.erase      = (st == S_ERASE);
    d.update     = (st == S_UPDATE);
    d.draw       = (st == S_DRAW);
    d.draw_end   = (st == S_END);
    d.idx        = idx;
    d.fc         = fc;
    d.ovr        = ovr;
    d.wd         = wd;
    return d;
  endfunction

  function automatic out_t act();
    return {bus.vga_en, bus.draw_start, bus.erase, bus.update, bus.draw,
            bus.draw_end, bus.layer_idx, bus.frame_cnt, bus.overrun,
            bus.wdog_timeout};
  endfunction

  function automatic void check(string name, out_t a, out_t e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, a, e);
  endfunction

  function automatic void add(string tag, logic sync, logic [1:0] gs,
                              logic [3:0] byp, logic de, logic dd, state_t st,
                              logic [1:0] idx, logic [15:0] fc, logic ovr,
                              logic wd = 1'b0);
    vec_t v;
    v.tag = tag; v.sync = sync; v.gs = gs; v.byp = byp; v.de = de; v.dd = dd;
    v.st = st; v.idx = idx; v.fc = fc; v.ovr = ovr; v.wd = wd;
    tbl.push_back(v);
  endfunction

  // Inputs are driven 1 time unit after the rising edge; this pushes the
  // expectation for the cycle that follows.
  task automatic apply(input vec_t v, input int n);
    sb_t s;
    bus.sync         = v.sync;
    bus.game_status  = v.gs;
    bus.bypass_erase = v.byp;
    bus.done_erase   = v.de;
    bus.done_draw    = v.dd;
    s.name = $sformatf("%s[%0d]", v.tag, n);
    s.e    = dec(v.st, v.idx, v.fc, v.ovr, v.wd);
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    tbl.delete();
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t s;
      s = sb.pop_front();
      check(s.name, act(), s.e);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sync = 1'b0; bus.game_status = GS_START; bus.bypass_erase = 4'b0000;
    bus.done_erase = 1'b0; bus.done_draw = 1'b0;

    @(posedge clk); #1;
    check("reset_state", act(), dec(S_START, 2'd0, 16'd0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // start screen, then play
    for (int k = 0; k < 5; k++)
      add("start", 0, GS_START, 4'h0, 0, 0, S_START, 0, 0, 0);
    add("start", 0, GS_PLAY, 4'h0, 0, 0, S_START, 0, 0, 0);
    add("start", 0, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    // decimation by 3, then full frame with no bypass
    add("div",   1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("div",   0, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("div",   1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("div",   0, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("div",   1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("erase", 0, GS_PLAY, 4'h0, 0, 1, S_ERASE, 0, 0, 0);
    add("erase", 0, GS_PLAY, 4'h0, 1, 0, S_ERASE, 0, 0, 0);
    add("erase", 0, GS_PLAY, 4'h0, 1, 0, S_ERASE, 1, 0, 0);
    add("erase", 0, GS_PLAY, 4'h0, 1, 0, S_ERASE, 2, 0, 0);
    add("erase", 0, GS_PLAY, 4'h0, 1, 0, S_ERASE, 3, 0, 0);
    add("upd",   0, GS_PLAY, 4'h0, 0, 0, S_UPDATE, 0, 0, 0);
    add("draw",  0, GS_PLAY, 4'h0, 0, 1, S_DRAW,  0, 1, 0);
    add("draw",  0, GS_PLAY, 4'h0, 1, 0, S_DRAW,  1, 1, 0);
    add("draw",  0, GS_PLAY, 4'h0, 0, 1, S_DRAW,  1, 1, 0);
    add("draw",  0, GS_PLAY, 4'h0, 0, 1, S_DRAW,  2, 1, 0);
    add("draw",  0, GS_PLAY, 4'h0, 0, 1, S_DRAW,  3, 1, 0);
    add("hold",  0, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 1, 0);
    // bypass 0101: erase walks layers 1 and 3; pause at update still draws
    add("skip",  1, GS_PLAY, 4'h5, 0, 0, S_HOLD,  0, 1, 0);
    add("skip",  1, GS_PLAY, 4'h5, 0, 0, S_HOLD,  0, 1, 0);
    add("skip",  1, GS_PLAY, 4'h5, 0, 0, S_HOLD,  0, 1, 0);
    add("skip",  0, GS_PLAY, 4'h5, 1, 0, S_ERASE, 1, 1, 0);
    add("skip",  0, GS_PAUSE, 4'h5, 1, 0, S_ERASE, 3, 1, 0);
    add("skip",  0, GS_PAUSE, 4'h5, 0, 0, S_UPDATE, 0, 1, 0);
    for (int k = 0; k < 4; k++)
      add("pdraw", 0, GS_PAUSE, 4'h5, 0, 1, S_DRAW, k[1:0], 2, 0);
    add("phold", 1, GS_PAUSE, 4'h5, 0, 0, S_HOLD, 0, 2, 0);
    add("phold", 0, GS_PLAY,  4'h5, 0, 0, S_HOLD, 0, 2, 0);
    // all bypassed: hold straight to update; game over at update
    add("allbp", 1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 2, 0);
    add("allbp", 1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 2, 0);
    add("allbp", 1, GS_PLAY, 4'hF, 0, 0, S_HOLD,  0, 2, 0);
    add("over",  0, GS_OVER, 4'hF, 0, 0, S_UPDATE, 0, 2, 0);
    add("over",  0, GS_OVER, 4'h0, 0, 0, S_END,   0, 3, 0);
    add("over",  0, GS_START, 4'h0, 0, 0, S_END,  0, 3, 0);
    add("restart", 0, GS_PLAY, 4'h0, 0, 0, S_START, 0, 3, 0);
    add("restart", 0, GS_PAUSE, 4'h0, 0, 0, S_HOLD, 0, 3, 0);
    // pause in hold: five syncs ignored, divider frozen
    for (int k = 0; k < 10; k++)
      add("pause", (k % 2) == 0, GS_PAUSE, 4'h0, 0, 0, S_HOLD, 0, 3, 0);
    // overrun: syncs during erase/update/draw pulse and are dropped
    add("ovr",   1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 3, 0);
    add("ovr",   1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 3, 0);
    add("ovr",   1, GS_PLAY, 4'hE, 0, 0, S_HOLD,  0, 3, 0);
    add("ovr",   1, GS_PLAY, 4'hE, 1, 0, S_ERASE, 0, 3, 1);
    add("ovr",   1, GS_PLAY, 4'hE, 0, 0, S_UPDATE, 0, 3, 1);
    add("ovr",   1, GS_PLAY, 4'hE, 0, 0, S_DRAW,  0, 4, 1);
    for (int k = 0; k < 4; k++)
      add("ovr", 0, GS_PLAY, 4'hE, 0, 1, S_DRAW, k[1:0], 4, 0);
    for (int k = 0; k < 5; k++)
      add("drop", (k % 2) == 1, GS_PLAY, 4'h0, 0, 0, S_HOLD, 0, 4, 0);
    add("drop",  1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 4, 0);
    add("drop",  0, GS_PLAY, 4'h0, 1, 0, S_ERASE, 0, 4, 0);
    run_table();

    // asynchronous reset in the middle of an erase walk
    check("pre_reset", act(), dec(S_ERASE, 2'd1, 16'd4, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1 check("async_reset", act(), dec(S_START, 2'd0, 16'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1 reset = 1'b0;

    add("wd_in", 0, GS_PLAY, 4'h0, 0, 0, S_START, 0, 0, 0);
    add("wd_in", 1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("wd_in", 1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
    add("wd_in", 1, GS_PLAY, 4'h0, 0, 0, S_HOLD,  0, 0, 0);
`ifdef DISP_SEQ_WATCHDOG_EN
    for (int k = 0; k < 15; k++)
      add("wd_wait", 0, GS_PLAY, 4'h0, 0, 0, S_ERASE, 0, 0, 0, 0);
    add("wd_hit",  0, GS_PLAY, 4'h0, 0, 0, S_ERASE, 0, 0, 0, 1);
    add("wd_adv",  0, GS_PLAY, 4'h0, 0, 0, S_ERASE, 1, 0, 0, 0);
`else
    for (int k = 0; k < 20; k++)
      add("no_wd", 0, GS_PLAY, 4'h0, 0, 0, S_ERASE, 0, 0, 0, 0);
`endif
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Parametrised frame sequencer for the VGA game display.
- Walks NUM_LAYERS drawable layers per frame: erase each non-bypassed layer, one update cycle, then draw every layer.
- Adds a pause state, a restartable game-over screen, frame decimation, a frame counter and overrun detection.
- Sits between the game-logic status output and the per-layer erase/draw engines that share the VGA write port.

Parameters:
- NUM_LAYERS, 4, number of layers walked per frame (1..16).
- FRAME_DIV, 1, process one frame every FRAME_DIV sync pulses (1..255).
- WDOG_CYCLES, 65535, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- sync  in  1  one-cycle frame pulse (vblank).
- game_status  in  2  00 start, 01 play, 10 game over, 11 pause.
- bypass_erase  in  NUM_LAYERS  bit i set = skip erase of layer i this frame.
- done_erase  in  1  one-cycle pulse: erase engine finished the current layer.
- done_draw  in  1  one-cycle pulse: draw engine finished the current layer.
- vga_en  out  1  VGA write enable.
- draw_start  out  1  start-screen engine active.
- erase  out  1  erase engine active for layer_idx.
- update  out  1  one-cycle game-state update strobe.
- draw  out  1  draw engine active for layer_idx.
- draw_end  out  1  game-over-screen engine active.
- layer_idx  out  clog2(NUM_LAYERS), min 1  current layer.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF to 0.
- overrun  out  1  one-cycle pulse: sync arrived while the frame was still in progress.
- wdog_timeout  out  1  one-cycle watchdog pulse.

Behaviour:
- Outputs are decoded combinationally from registered state, layer_idx and counters. Reset acts immediately, including mid-frame.
- Reset values:
  - state S_START, so vga_en=1 and draw_start=1.
  - erase, draw, update, draw_end = 0.
  - layer_idx=0, frame_cnt=0, frame-divider count=0.
  - overrun=0, wdog_timeout=0.
- Output decode per state:
  - S_START: draw_start=1.
  - S_HOLD: vga_en=1 only.
  - S_ERASE: erase=1.
  - S_UPDATE: update=1, vga_en=0.
  - S_DRAW: draw=1.
  - S_END: draw_end=1.
  - vga_en=1 in every state except S_UPDATE.
- S_START: status 01 -> S_HOLD; status 10 -> S_END; 00/11 -> stay.
- S_HOLD:
  - status 00 -> S_START; status 10 -> S_END. These are checked every cycle.
  - status 11 (pause): stay; sync ignored; divider frozen.
  - status 01 with sync: divider increments. When it reaches FRAME_DIV-1 it clears, and the FSM goes to S_ERASE with layer_idx set to the lowest non-bypassed layer. If all layers are bypassed it goes straight to S_UPDATE.
- S_ERASE:
  - On done_erase, layer_idx advances to the next higher non-bypassed layer, with no idle cycle.
  - If there is no higher non-bypassed layer, go to S_UPDATE.
  - bypass_erase is sampled live at each advance.
- S_UPDATE:
  - Exactly one cycle; frame_cnt increments; layer_idx set to 0.
  - Next state: status 00 -> S_START; status 10 -> S_END; status 01/11 -> S_DRAW. Pause still completes the current frame.
- S_DRAW: on done_draw, layer_idx+1. After layer NUM_LAYERS-1 completes, go to S_HOLD with layer_idx=0. No layer is skipped in the draw walk.
- S_END: stay until status==00, then -> S_START (restart).
- done_erase/done_draw outside their own state are ignored.
- sync in S_ERASE, S_UPDATE or S_DRAW: overrun pulses the same cycle; the sync is dropped, not queued.
- sync and done in the same cycle: the done is processed normally and overrun also pulses.

Optional Feature:
- Macro: DISP_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs while in S_ERASE or S_DRAW and clears on every done pulse or state change.
  - Reaching WDOG_CYCLES-1 forces an advance exactly as if the done pulse had arrived, and pulses wdog_timeout.
- Undefined: no counter; wdog_timeout tied 0; the FSM waits indefinitely for done pulses.

Decomposition:
- Package disp_pkg:
  - state enum (S_START, S_HOLD, S_ERASE, S_UPDATE, S_DRAW, S_END);
  - game_status encodings GS_START/GS_PLAY/GS_OVER/GS_PAUSE;
  - FRAME_CNT_W=16.
- Sub-module disp_layer_sel: combinational priority search for the next non-bypassed layer above a given index, plus a found flag. Instantiated once, for the erase walk.

Test Plan:
- Start to play: reset, status=00 for 5 cycles, then 01 -> draw_start=1 throughout the 00 period, then S_HOLD.
- Full frame, NUM_LAYERS=4, bypass_erase=0000: sync, then done_erase ×4 -> layer_idx 0,1,2,3; update for 1 cycle with vga_en=0; done_draw ×4; back in S_HOLD; frame_cnt=1.
- Erase skip: bypass_erase=0101, sync -> erase walks layer_idx 1 then 3. bypass_erase=1111 -> S_HOLD to S_UPDATE directly.
- Decimation and pause: FRAME_DIV=3, three syncs -> erase only after the third. status=11 in S_HOLD with 5 syncs -> no erase, frame_cnt unchanged.
- Overrun and restart: sync during S_DRAW -> overrun pulses 1 cycle and the frame finishes normally. status=10 at S_UPDATE -> S_END, draw_end=1. status=00 -> S_START. Reset asserted mid-S_ERASE -> S_START immediately with frame_cnt=0.
- Watchdog (macro defined, WDOG_CYCLES=16): withhold done_erase -> wdog_timeout pulses at cycle 16 in the state and layer_idx advances.
